conv_read_addr_gen: RTL and testbench

- Hardware read-address sequencer directly upstream of npu_simple.
- Scans one feature map held in the NPU input buffer in 2x2 max-pool order.
- For each output pixel, emits the nine 3x3-tap read addresses (readi_w/readi_h) and the zero-padding tap mask (en_read).
- Replaces bench-side address generation, so npu_simple's en_mp pooling receives its four operands on consecutive beats.

---
 rtl/conv_read_addr_gen.sv | 214 +++++++++++++++++++++
 tb/tb_conv_read_addr_gen.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_read_addr_gen.sv
// Read-address sequencer for npu_simple: walks one feature map in 2x2 max-pool order
// and emits the nine 3x3-tap addresses plus the zero-padding enable mask per beat.
module conv_read_addr_gen #(
    parameter int WIDTH_B  = 7,
    parameter int HEIGHT_B = 3,
    parameter int FMAP_W   = 8,
    parameter int FMAP_H   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  out_valid,
    output logic [8:0]            en_read,
    output logic [WIDTH_B*9-1:0]  readi_w,
    output logic [HEIGHT_B*9-1:0] readi_h,
    output logic [WIDTH_B-1:0]    pos_w,
    output logic [HEIGHT_B-1:0]   pos_h,
    output logic [1:0]            mp_idx,
    output logic                  mp_last,
    output logic                  done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [WIDTH_B-1:0]  K_LAST   = WIDTH_B'(FMAP_W - 2);
    localparam logic [HEIGHT_B-1:0] J_LAST   = HEIGHT_B'(FMAP_H - 2);
    localparam logic [WIDTH_B:0]    FMAP_W_X = (WIDTH_B + 1)'(FMAP_W);
    localparam logic [HEIGHT_B:0]   FMAP_H_X = (HEIGHT_B + 1)'(FMAP_H);

    state_t                state_q, state_d;
    logic                  busy_q, busy_d;
    logic                  valid_q, valid_d;
    logic                  done_q, done_d;
    logic [8:0]            en_q, en_d;
    logic [WIDTH_B*9-1:0]  rw_q, rw_d;
    logic [HEIGHT_B*9-1:0] rh_q, rh_d;
    logic [WIDTH_B-1:0]    pw_q, pw_d;
    logic [HEIGHT_B-1:0]   ph_q, ph_d;
    logic [1:0]            mp_q, mp_d;
    logic                  mp_last_q, mp_last_d;
    logic [WIDTH_B-1:0]    k_q, k_d, k_nxt;
    logic [HEIGHT_B-1:0]   j_q, j_d, j_nxt;
    logic [1:0]            l_q, l_d, l_nxt;
    logic                  last_beat;

    logic [WIDTH_B-1:0]    beat_k, beat_pw;
    logic [HEIGHT_B-1:0]   beat_j, beat_ph;
    logic [1:0]            beat_l;
    logic [8:0]            beat_en;
    logic [WIDTH_B*9-1:0]  beat_w;
    logic [HEIGHT_B*9-1:0] beat_h;
    logic [WIDTH_B:0]      wx;
    logic [HEIGHT_B:0]     hx;
    logic                  load_beat;

    // Pool-order counter advance: l innermost, then k by 2, then j by 2
    always_comb begin
        k_nxt = k_q;
        j_nxt = j_q;
        l_nxt = l_q + 2'd1;
        if (l_q == 2'd3) begin
            if (k_q == K_LAST) begin
                k_nxt = '0;
                j_nxt = j_q + HEIGHT_B'(2);
            end else begin
                k_nxt = k_q + WIDTH_B'(2);
            end
        end
        last_beat = (l_q == 2'd3) && (k_q == K_LAST) && (j_q == J_LAST);
    end

    // The beat being loaded is the origin on start, otherwise the advanced counters
    always_comb begin
        beat_k = (state_q == IDLE) ? '0 : k_nxt;
        beat_j = (state_q == IDLE) ? '0 : j_nxt;
        beat_l = (state_q == IDLE) ? '0 : l_nxt;
        beat_pw = beat_k + WIDTH_B'(beat_l[1]);
        beat_ph = beat_j + HEIGHT_B'(beat_l[0]);
        beat_en = '0;
        beat_w  = '0;
        beat_h  = '0;
        wx      = '0;
        hx      = '0;
        // One extra bit makes -1 wrap to all-ones, so a single unsigned compare rejects both edges
        for (int t = 0; t < 9; t++) begin
            wx = {1'b0, beat_pw} + (WIDTH_B + 1)'(t % 3) - (WIDTH_B + 1)'(1);
            hx = {1'b0, beat_ph} + (HEIGHT_B + 1)'(t / 3) - (HEIGHT_B + 1)'(1);
            if ((wx < FMAP_W_X) && (hx < FMAP_H_X)) begin
                beat_en[8-t]                        = 1'b1;
                beat_w[(8-t)*WIDTH_B +: WIDTH_B]    = wx[WIDTH_B-1:0];
                beat_h[(8-t)*HEIGHT_B +: HEIGHT_B]  = hx[HEIGHT_B-1:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        valid_d   = valid_q;
        done_d    = 1'b0;
        en_d      = en_q;
        rw_d      = rw_q;
        rh_d      = rh_q;
        pw_d      = pw_q;
        ph_d      = ph_q;
        mp_d      = mp_q;
        mp_last_d = mp_last_q;
        k_d       = k_q;
        j_d       = j_q;
        l_d       = l_q;
        load_beat = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    busy_d    = 1'b1;
                    valid_d   = 1'b1;
                    k_d       = '0;
                    j_d       = '0;
                    l_d       = '0;
                    load_beat = 1'b1;
                end
            end
            RUN: begin
                if (valid_q && out_ready) begin
                    if (last_beat) begin
                        state_d   = DONE;
                        busy_d    = 1'b0;
                        valid_d   = 1'b0;
                        done_d    = 1'b1;
                        en_d      = '0;
                        rw_d      = '0;
                        rh_d      = '0;
                        pw_d      = '0;
                        ph_d      = '0;
                        mp_d      = '0;
                        mp_last_d = 1'b0;
                        k_d       = '0;
                        j_d       = '0;
                        l_d       = '0;
                    end else begin
                        k_d       = k_nxt;
                        j_d       = j_nxt;
                        l_d       = l_nxt;
                        load_beat = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (load_beat) begin
            en_d      = beat_en;
            rw_d      = beat_w;
            rh_d      = beat_h;
            pw_d      = beat_pw;
            ph_d      = beat_ph;
            mp_d      = beat_l;
            mp_last_d = (beat_l == 2'd3);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            en_q      <= '0;
            rw_q      <= '0;
            rh_q      <= '0;
            pw_q      <= '0;
            ph_q      <= '0;
            mp_q      <= '0;
            mp_last_q <= 1'b0;
            k_q       <= '0;
            j_q       <= '0;
            l_q       <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            en_q      <= en_d;
            rw_q      <= rw_d;
            rh_q      <= rh_d;
            pw_q      <= pw_d;
            ph_q      <= ph_d;
            mp_q      <= mp_d;
            mp_last_q <= mp_last_d;
            k_q       <= k_d;
            j_q       <= j_d;
            l_q       <= l_d;
        end
    end

    assign busy      = busy_q;
    assign out_valid = valid_q;
    assign done      = done_q;
    assign en_read   = en_q;
    assign readi_w   = rw_q;
    assign readi_h   = rh_q;
    assign pos_w     = pw_q;
    assign pos_h     = ph_q;
    assign mp_idx    = mp_q;
    assign mp_last   = mp_last_q;

endmodule

// File: tb/tb_conv_read_addr_gen.sv
// Directed bench for conv_read_addr_gen on an 8x4 map: tabled tap vectors, full scan,
// back-pressure hold, ignored start pulses and mid-scan reset.
module tb_conv_read_addr_gen;

    localparam int WIDTH_B  = 7;
    localparam int HEIGHT_B = 3;
    localparam int FMAP_W   = 8;
    localparam int FMAP_H   = 4;
    localparam int BEATS    = FMAP_W * FMAP_H;

    logic                  clk;
    logic                  reset;
    logic                  start;
    logic                  out_ready;
    logic                  busy;
    logic                  out_valid;
    logic [8:0]            en_read;
    logic [WIDTH_B*9-1:0]  readi_w;
    logic [HEIGHT_B*9-1:0] readi_h;
    logic [WIDTH_B-1:0]    pos_w;
    logic [HEIGHT_B-1:0]   pos_h;
    logic [1:0]            mp_idx;
    logic                  mp_last;
    logic                  done;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int                    beat;
        logic [WIDTH_B-1:0]    pw;
        logic [HEIGHT_B-1:0]   ph;
        logic [1:0]            mp;
        logic                  last;
        logic [8:0]            en;
        logic [WIDTH_B*9-1:0]  rw;
        logic [HEIGHT_B*9-1:0] rh;
    } vec_t;

    vec_t vecs[7];

    conv_read_addr_gen #(
        .WIDTH_B(WIDTH_B), .HEIGHT_B(HEIGHT_B), .FMAP_W(FMAP_W), .FMAP_H(FMAP_H)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .out_ready(out_ready),
        .busy(busy), .out_valid(out_valid), .en_read(en_read),
        .readi_w(readi_w), .readi_h(readi_h), .pos_w(pos_w), .pos_h(pos_h),
        .mp_idx(mp_idx), .mp_last(mp_last), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [127:0] actual, input logic [127:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected centre for scan beat b, derived from 2x2 group numbering
    task automatic model_pos(input int b, output int pw, output int ph, output int mp);
        int grp;
        grp = b / 4;
        mp  = b % 4;
        pw  = (grp % (FMAP_W / 2)) * 2 + mp / 2;
        ph  = (grp / (FMAP_W / 2)) * 2 + mp % 2;
    endtask

    task automatic check_beat(input int b);
        int pw, ph, mp;
        model_pos(b, pw, ph, mp);
        check_output($sformatf("valid_b%0d", b), 128'(out_valid), 128'(1));
        check_output($sformatf("busy_b%0d", b), 128'(busy), 128'(1));
        check_output($sformatf("done_b%0d", b), 128'(done), 128'(0));
        check_output($sformatf("pos_w_b%0d", b), 128'(pos_w), 128'(pw));
        check_output($sformatf("pos_h_b%0d", b), 128'(pos_h), 128'(ph));
        check_output($sformatf("mp_idx_b%0d", b), 128'(mp_idx), 128'(mp));
        check_output($sformatf("mp_last_b%0d", b), 128'(mp_last), 128'(mp == 3));
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].beat == b) begin
                check_output($sformatf("vec_pos_b%0d", b), 128'({pos_w, pos_h, mp_idx, mp_last}),
                             128'({vecs[i].pw, vecs[i].ph, vecs[i].mp, vecs[i].last}));
                check_output($sformatf("en_read_b%0d", b), 128'(en_read), 128'(vecs[i].en));
                check_output($sformatf("readi_w_b%0d", b), 128'(readi_w), 128'(vecs[i].rw));
                check_output($sformatf("readi_h_b%0d", b), 128'(readi_h), 128'(vecs[i].rh));
            end
        end
    endtask

    task automatic apply_stimulus_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    logic [127:0] snap_a;
    logic [127:0] snap_b;

    initial begin
        vecs[0] = '{0, 7'd0, 3'd0, 2'd0, 1'b0, 9'b000011011,
                    {7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd1, 7'd0, 7'd0, 7'd1},
                    {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1}};
        vecs[1] = '{1, 7'd0, 3'd1, 2'd1, 1'b0, 9'b011011011,
                    {7'd0, 7'd0, 7'd1, 7'd0, 7'd0, 7'd1, 7'd0, 7'd0, 7'd1},
                    {3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd0, 3'd2, 3'd2}};
        vecs[2] = '{2, 7'd1, 3'd0, 2'd2, 1'b0, 9'b000111111,
                    {7'd0, 7'd0, 7'd0, 7'd0, 7'd1, 7'd2, 7'd0, 7'd1, 7'd2},
                    {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1}};
        vecs[3] = '{3, 7'd1, 3'd1, 2'd3, 1'b1, 9'h1FF,
                    {7'd0, 7'd1, 7'd2, 7'd0, 7'd1, 7'd2, 7'd0, 7'd1, 7'd2},
                    {3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2}};
        vecs[4] = '{4, 7'd2, 3'd0, 2'd0, 1'b0, 9'b000111111,
                    {7'd0, 7'd0, 7'd0, 7'd1, 7'd2, 7'd3, 7'd1, 7'd2, 7'd3},
                    {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1}};
        vecs[5] = '{7, 7'd3, 3'd1, 2'd3, 1'b1, 9'h1FF,
                    {7'd2, 7'd3, 7'd4, 7'd2, 7'd3, 7'd4, 7'd2, 7'd3, 7'd4},
                    {3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2}};
        vecs[6] = '{31, 7'd7, 3'd3, 2'd3, 1'b1, 9'b110110000,
                    {7'd6, 7'd7, 7'd0, 7'd6, 7'd7, 7'd0, 7'd0, 7'd0, 7'd0},
                    {3'd2, 3'd2, 3'd0, 3'd3, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0}};

        reset     = 1'b1;
        start     = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        check_output("reset_ctrl", 128'({busy, out_valid, done}), 128'(0));
        check_output("reset_beat", 128'({en_read, pos_w, pos_h, mp_idx, mp_last}), 128'(0));
        check_output("reset_addr", 128'({readi_w, readi_h}), 128'(0));
        reset = 1'b0;
        step();
        check_output("idle_ready_no_effect", 128'({busy, out_valid}), 128'(0));

        // Full scan with a 5-cycle stall at beat 10 and a stray start at beat 6
        begin
            int beat;
            int cycles;
            bit stalled;
            beat    = 0;
            cycles  = 0;
            stalled = 1'b0;
            apply_stimulus_start();
            while (beat < BEATS && cycles < 400) begin
                cycles++;
                if (!out_valid) begin
                    check_output($sformatf("valid_wait_b%0d", beat), 128'(out_valid), 128'(1));
                    step();
                end else begin
                    check_beat(beat);
                    if (beat == 10 && !stalled) begin
                        stalled   = 1'b1;
                        out_ready = 1'b0;
                        snap_a = 128'({busy, out_valid, done, en_read, pos_w, pos_h, mp_idx, mp_last, readi_h});
                        snap_b = 128'(readi_w);
                        for (int s = 0; s < 5; s++) begin
                            step();
                            check_output($sformatf("stall_hold_a%0d", s),
                                128'({busy, out_valid, done, en_read, pos_w, pos_h, mp_idx, mp_last, readi_h}), snap_a);
                            check_output($sformatf("stall_hold_b%0d", s), 128'(readi_w), snap_b);
                        end
                        out_ready = 1'b1;
                        check_beat(beat);
                    end
                    if (beat == 6) start = 1'b1;
                    step();
                    start = 1'b0;
                    beat++;
                end
            end
            check_output("beat_count", 128'(beat), 128'(BEATS));
            check_output("done_pulse", 128'({done, busy, out_valid}), 128'(3'b100));
            start = 1'b1;
            step();
            start = 1'b0;
            check_output("done_single", 128'(done), 128'(0));
            check_output("start_in_done_ignored", 128'({busy, out_valid}), 128'(0));
            step();
            check_output("idle_after_done", 128'({busy, out_valid, done}), 128'(0));
        end

        // Mid-scan reset at beat 20, then a clean restart
        begin
            int beat;
            int cycles;
            beat   = 0;
            cycles = 0;
            apply_stimulus_start();
            while (beat < 20 && cycles < 200) begin
                cycles++;
                if (out_valid) begin
                    check_beat(beat);
                    beat++;
                end
                step();
            end
            check_output("reached_beat20", 128'(beat), 128'(20));
            check_beat(20);
            reset = 1'b1;
            #1;
            check_output("async_reset_now", 128'({busy, out_valid, done, en_read, pos_w, pos_h}), 128'(0));
            step();
            check_output("reset_mid_ctrl", 128'({busy, out_valid, done}), 128'(0));
            reset = 1'b0;
            step();
            check_output("reset_mid_no_done", 128'({busy, out_valid, done}), 128'(0));
            apply_stimulus_start();
            check_beat(0);
            step();
            check_beat(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
